// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: per-axis region encoding, standard mode tables
// and the position-to-region decoder used by both raster axes.
package vga_pkg;

  typedef enum logic [1:0] {
    AX_DISPLAY,
    AX_FRONT,
    AX_SYNC,
    AX_BACK
  } axis_region_e;

  typedef struct packed {
    int hd;
    int hf;
    int hs;
    int hb;
    int vd;
    int vf;
    int vs;
    int vb;
    bit hs_pol;
    bit vs_pol;
  } vga_mode_t;

  // 640x480@60, 25 MHz pixel clock
  localparam vga_mode_t VGA_640X480 = '{hd: 640, hf: 16, hs: 96, hb: 48,
                                        vd: 480, vf: 10, vs: 2,  vb: 33,
                                        hs_pol: 1'b0, vs_pol: 1'b0};
  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam vga_mode_t VGA_800X600 = '{hd: 800, hf: 40, hs: 128, hb: 88,
                                        vd: 600, vf: 1,  vs: 4,   vb: 23,
                                        hs_pol: 1'b1, vs_pol: 1'b1};

  function automatic axis_region_e axis_region(int pos, int d, int f, int s);
    if (pos < d)
      return AX_DISPLAY;
    else if (pos < d + f)
      return AX_FRONT;
    else if (pos < d + f + s)
      return AX_SYNC;
    return AX_BACK;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the raster timing signals between the generator and its consumers.
interface vga_timing_gen_if #(
  parameter int CW = 10,
  parameter int FW = 8
) ();

  logic          en;
  logic          restart;
  logic          p_tick;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic [FW-1:0] frame_cnt;

  modport master (
    input  en, restart,
    output p_tick, hsync, vsync, video_on, x, y, line_start, frame_start, frame_cnt
  );

  modport slave (
    output en, restart,
    input  p_tick, hsync, vsync, video_on, x, y, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter wrapping at D+F+S+B, with combinational
// wrap, sync and display decodes of the current (pre-update) position.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int D   = 640,
  parameter int F   = 16,
  parameter int S   = 96,
  parameter int B   = 48,
  parameter bit POL = 1'b0,
  parameter int CW  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_tick,
  input  logic          i_restart,
  output logic          o_wrap,
  output logic [CW-1:0] o_count,
  output logic          o_sync,
  output logic          o_active
);

  localparam int TOTAL = D + F + S + B;

  logic [CW-1:0] r_count;
  axis_region_e  w_region;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (i_restart)
      r_count <= '0;
    else if (i_tick)
      r_count <= o_wrap ? '0 : r_count + CW'(1);
  end

  assign w_region = axis_region(int'(r_count), D, F, S);
  assign o_wrap   = (r_count == CW'(TOTAL - 1));
  assign o_count  = r_count;
  assign o_sync   = (w_region == AX_SYNC) ? POL : ~POL;
  assign o_active = (w_region == AX_DISPLAY);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator on the system clock; pixel rate set
// by a clock-enable divider, all timing outputs registered and aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int HD      = VGA_640X480.hd,
  parameter int HF      = VGA_640X480.hf,
  parameter int HS      = VGA_640X480.hs,
  parameter int HB      = VGA_640X480.hb,
  parameter int VD      = VGA_640X480.vd,
  parameter int VF      = VGA_640X480.vf,
  parameter int VS      = VGA_640X480.vs,
  parameter int VB      = VGA_640X480.vb,
  parameter bit HS_POL  = VGA_640X480.hs_pol,
  parameter bit VS_POL  = VGA_640X480.vs_pol,
  parameter int CW      = 10,
  parameter int FW      = 8
) (
  input  logic          clk_100MHz,
  input  logic          reset_n,
  input  logic          en,
  input  logic          restart,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int HTOTAL = HD + HF + HS + HB;
  localparam int VTOTAL = VD + VF + VS + VB;
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (HD < 1 || HF < 1 || HS < 1 || HB < 1 || VD < 1 || VF < 1 || VS < 1 || VB < 1
      || CW < 1 || FW < 1) begin : g_chk_width
    $error("vga_timing_gen: every timing and width field must be >= 1");
  end
  if (HTOTAL > 2**CW || VTOTAL > 2**CW) begin : g_chk_fit
    $error("vga_timing_gen: raster totals do not fit in CW bits");
  end

  logic          r_running;
  logic [DW-1:0] r_div;
  logic          w_div_last, w_tick, w_restart;
  logic          w_h_wrap, w_v_wrap, w_h_sync, w_v_sync, w_h_active, w_v_active;
  logic [CW-1:0] w_h_cnt, w_v_cnt;

  logic          r_hsync, r_vsync, r_video_on, r_line_start, r_frame_start;
  logic [CW-1:0] r_x, r_y;
  logic [FW-1:0] r_frame_cnt;

  assign w_div_last = (r_div == DW'(CLK_DIV - 1));
  assign w_tick     = en & r_running & w_div_last;
  assign w_restart  = w_tick & restart;

  // Divider stays parked until running is set, so the first strobe lands a
  // fixed number of clocks after reset release for every CLK_DIV.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_running <= 1'b0;
      r_div     <= '0;
    end else begin
      r_running <= 1'b1;
      if (en && r_running)
        r_div <= w_div_last ? '0 : r_div + DW'(1);
    end
  end

  vga_axis_counter #(
    .D(HD), .F(HF), .S(HS), .B(HB), .POL(HS_POL), .CW(CW)
  ) u_h_axis (
    .clk       (clk_100MHz),
    .rst_n     (reset_n),
    .i_tick    (w_tick),
    .i_restart (w_restart),
    .o_wrap    (w_h_wrap),
    .o_count   (w_h_cnt),
    .o_sync    (w_h_sync),
    .o_active  (w_h_active)
  );

  vga_axis_counter #(
    .D(VD), .F(VF), .S(VS), .B(VB), .POL(VS_POL), .CW(CW)
  ) u_v_axis (
    .clk       (clk_100MHz),
    .rst_n     (reset_n),
    .i_tick    (w_tick & w_h_wrap),
    .i_restart (w_restart),
    .o_wrap    (w_v_wrap),
    .o_count   (w_v_cnt),
    .o_sync    (w_v_sync),
    .o_active  (w_v_active)
  );

  // A restart presents pixel (0,0) directly; a coincident natural wrap still
  // advances the frame counter exactly once.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else if (w_tick) begin
      if (restart) begin
        r_x           <= '0;
        r_y           <= '0;
        r_hsync       <= ~HS_POL;
        r_vsync       <= ~VS_POL;
        r_video_on    <= 1'b1;
        r_line_start  <= 1'b1;
        r_frame_start <= 1'b1;
      end else begin
        r_x           <= w_h_cnt;
        r_y           <= w_v_cnt;
        r_hsync       <= w_h_sync;
        r_vsync       <= w_v_sync;
        r_video_on    <= w_h_active & w_v_active;
        r_line_start  <= (w_h_cnt == '0);
        r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
      end
      if (w_h_wrap && w_v_wrap)
        r_frame_cnt <= r_frame_cnt + FW'(1);
    end
  end

  assign p_tick      = w_tick;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for divider/line/enable/restart/reset,
// and a 7x5 raster instance for vertical timing and frame counting.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst2_n, en2, restart2;
  int   n_checks = 0;
  int   n_errors = 0;

  vga_timing_gen_if #(.CW(10), .FW(8)) vif ();

  vga_timing_gen u_dut (
    .clk_100MHz  (clk),
    .reset_n     (rst_n),
    .en          (vif.en),
    .restart     (vif.restart),
    .p_tick      (vif.p_tick),
    .hsync       (vif.hsync),
    .vsync       (vif.vsync),
    .video_on    (vif.video_on),
    .x           (vif.x),
    .y           (vif.y),
    .line_start  (vif.line_start),
    .frame_start (vif.frame_start),
    .frame_cnt   (vif.frame_cnt)
  );

  logic       p_tick2, hsync2, vsync2, video2, ls2, fs2;
  logic [3:0] x2, y2;
  logic [7:0] fc2;

  vga_timing_gen #(
    .CLK_DIV(1), .HD(4), .HF(1), .HS(1), .HB(1),
    .VD(2), .VF(1), .VS(1), .VB(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(4), .FW(8)
  ) u_small (
    .clk_100MHz  (clk),
    .reset_n     (rst2_n),
    .en          (en2),
    .restart     (restart2),
    .p_tick      (p_tick2),
    .hsync       (hsync2),
    .vsync       (vsync2),
    .video_on    (video2),
    .x           (x2),
    .y           (y2),
    .line_start  (ls2),
    .frame_start (fs2),
    .frame_cnt   (fc2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance until the default instance consumes one pixel strobe, then sample.
  task automatic next_pix();
    int n = 0;
    while (vif.p_tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("tick_timeout", 32'(0), 32'(1));
    @(negedge clk);
  endtask

  task automatic check_reset_release(input string tag);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check({tag, "_ptick"}, 32'(vif.p_tick), 32'(k == 4));
    end
    @(negedge clk);
    check({tag, "_x"}, 32'(vif.x), 32'(0));
    check({tag, "_y"}, 32'(vif.y), 32'(0));
    check({tag, "_fs"}, 32'(vif.frame_start), 32'(1));
    check({tag, "_ls"}, 32'(vif.line_start), 32'(1));
    check({tag, "_von"}, 32'(vif.video_on), 32'(1));
    check({tag, "_hs"}, 32'(vif.hsync), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lows, first_low, last_low, vid, bad, ticks, changed, ex, ey, ec;
    logic [32:0] snap, cur;

    rst_n = 1'b0; rst2_n = 1'b0;
    vif.en = 1'b1; vif.restart = 1'b0;
    en2 = 1'b1; restart2 = 1'b0;

    // Reset values
    repeat (5) @(negedge clk);
    check("rst_hsync", 32'(vif.hsync), 32'(1));
    check("rst_vsync", 32'(vif.vsync), 32'(1));
    check("rst_ptick", 32'(vif.p_tick), 32'(0));
    check("rst_x", 32'(vif.x), 32'(0));
    check("rst_von", 32'(vif.video_on), 32'(0));
    check("rst_fs", 32'(vif.frame_start), 32'(0));
    check("rst_fc", 32'(vif.frame_cnt), 32'(0));
    check("rst_small_hsync", 32'(hsync2), 32'(0));
    rst_n = 1'b1;
    check_reset_release("first");

    // Strobe period
    n = 0;
    while (vif.p_tick !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (vif.p_tick !== 1'b1 && n < 16);
    check("tick_period", 32'(n), 32'(4));

    // Full line 1
    n = 0;
    while (!(vif.x == 0 && vif.y == 1) && n < 1000) begin next_pix(); n++; end
    check("line1_y", 32'(vif.y), 32'(1));
    check("line1_ls", 32'(vif.line_start), 32'(1));
    check("line1_fs", 32'(vif.frame_start), 32'(0));
    lows = 0; first_low = -1; last_low = -1; vid = 0; bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (vif.x != 10'(i)) bad++;
      if (vif.hsync == 1'b0) begin
        lows++;
        if (first_low < 0) first_low = i;
        last_low = i;
      end
      if (vif.video_on) vid++;
      next_pix();
    end
    check("x_sequence", 32'(bad), 32'(0));
    check("hs_low_count", 32'(lows), 32'(96));
    check("hs_first_low", 32'(first_low), 32'(656));
    check("hs_last_low", 32'(last_low), 32'(751));
    check("video_count", 32'(vid), 32'(640));
    check("line_wrap_x", 32'(vif.x), 32'(0));
    check("line_wrap_y", 32'(vif.y), 32'(2));
    check("line1_vsync", 32'(vif.vsync), 32'(1));

    // Enable freeze at x=100
    n = 0;
    while (vif.x != 100 && n < 200) begin next_pix(); n++; end
    check("freeze_at_x", 32'(vif.x), 32'(100));
    vif.en = 1'b0;
    snap = {vif.hsync, vif.vsync, vif.video_on, vif.line_start, vif.frame_start,
            vif.x, vif.y, vif.frame_cnt};
    ticks = 0; changed = 0;
    repeat (50) begin
      @(negedge clk);
      cur = {vif.hsync, vif.vsync, vif.video_on, vif.line_start, vif.frame_start,
             vif.x, vif.y, vif.frame_cnt};
      if (vif.p_tick !== 1'b0) ticks++;
      if (cur !== snap) changed++;
    end
    vif.en = 1'b1;
    check("freeze_ptick", 32'(ticks), 32'(0));
    check("freeze_hold", 32'(changed), 32'(0));
    next_pix();
    check("resume_x", 32'(vif.x), 32'(101));
    check("resume_y", 32'(vif.y), 32'(2));

    // Restart: between ticks ignored, on a tick jumps to (0,0)
    n = 0;
    while (vif.x != 299 && n < 400) begin next_pix(); n++; end
    check("restart_idle_ptick", 32'(vif.p_tick), 32'(0));
    vif.restart = 1'b1;
    @(negedge clk);
    vif.restart = 1'b0;
    next_pix();
    check("restart_ignored_x", 32'(vif.x), 32'(300));
    check("restart_ignored_y", 32'(vif.y), 32'(2));
    vif.restart = 1'b1;
    next_pix();
    vif.restart = 1'b0;
    check("restart_x", 32'(vif.x), 32'(0));
    check("restart_y", 32'(vif.y), 32'(0));
    check("restart_fs", 32'(vif.frame_start), 32'(1));
    check("restart_fc", 32'(vif.frame_cnt), 32'(0));

    // Mid-frame reset
    n = 0;
    while (!(vif.y == 1 && vif.x == 50) && n < 1000) begin next_pix(); n++; end
    rst_n = 1'b0;
    #1;
    check("mrst_x", 32'(vif.x), 32'(0));
    check("mrst_y", 32'(vif.y), 32'(0));
    check("mrst_hs", 32'(vif.hsync), 32'(1));
    check("mrst_vs", 32'(vif.vsync), 32'(1));
    check("mrst_von", 32'(vif.video_on), 32'(0));
    check("mrst_ls", 32'(vif.line_start), 32'(0));
    check("mrst_ptick", 32'(vif.p_tick), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_release("mrst");

    // Small raster: 7 x 5, one pixel per clock
    @(negedge clk);
    rst2_n = 1'b1;
    #1;
    check("s_first_cycle_ptick", 32'(p_tick2), 32'(0));
    @(negedge clk);
    check("s_second_cycle_ptick", 32'(p_tick2), 32'(1));
    @(negedge clk);
    for (int i = 0; i < 70; i++) begin
      ex = i % 7;
      ey = (i / 7) % 5;
      ec = (i + 1) / 35;
      check("s_x", 32'(x2), 32'(ex));
      check("s_y", 32'(y2), 32'(ey));
      check("s_hsync", 32'(hsync2), 32'(ex == 5));
      check("s_vsync", 32'(vsync2), 32'(ey != 3));
      check("s_video", 32'(video2), 32'(ex < 4 && ey < 2));
      check("s_ls", 32'(ls2), 32'(ex == 0));
      check("s_fs", 32'(fs2), 32'(ex == 0 && ey == 0));
      check("s_fc", 32'(fc2), 32'(ec));
      @(negedge clk);
    end

    n = 0;
    while (!(x2 == 3 && y2 == 1) && n < 40) begin @(negedge clk); n++; end
    restart2 = 1'b1;
    @(negedge clk);
    restart2 = 1'b0;
    check("s_restart_x", 32'(x2), 32'(0));
    check("s_restart_y", 32'(y2), 32'(0));
    check("s_restart_fs", 32'(fs2), 32'(1));
    check("s_restart_fc", 32'(fc2), 32'(2));

    n = 0;
    while (!(x2 == 5 && y2 == 4) && n < 40) begin @(negedge clk); n++; end
    restart2 = 1'b1;
    @(negedge clk);
    restart2 = 1'b0;
    check("s_wrap_restart_x", 32'(x2), 32'(0));
    check("s_wrap_restart_y", 32'(y2), 32'(0));
    check("s_wrap_restart_fc", 32'(fc2), 32'(3));

    n = 0;
    while (!(x2 == 2 && y2 == 2) && n < 40) begin @(negedge clk); n++; end
    rst2_n = 1'b0;
    #1;
    check("s_mrst_fc", 32'(fc2), 32'(0));
    check("s_mrst_x", 32'(x2), 32'(0));
    check("s_mrst_y", 32'(y2), 32'(0));
    check("s_mrst_hsync", 32'(hsync2), 32'(0));
    check("s_mrst_vsync", 32'(vsync2), 32'(1));
    check("s_mrst_ptick", 32'(p_tick2), 32'(0));
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (2) @(negedge clk);
    check("s_mrst_restart_x", 32'(x2), 32'(0));
    check("s_mrst_restart_fs", 32'(fs2), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
